// File: rtl/sa_dma_pkg.sv
// Shared definitions for the systolic-array DMA bridge.
// Holds the default transfer sizes, capture latency, the core request codes
// and the bridge state encoding.
package sa_dma_pkg;

  localparam int unsigned IN_WORDS_DEF  = 32;
  localparam int unsigned OUT_WORDS_DEF = 16;
  localparam int unsigned CAP_LAT_DEF   = 2;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REQ_W     = 2;
  localparam int unsigned IN_CNT_W  = 6;
  localparam int unsigned OUT_CNT_W = 5;

  localparam logic [REQ_W-1:0] REQ_LOAD  = 2'b10;
  localparam logic [REQ_W-1:0] REQ_STORE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_CAP_WAIT = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

  // One AXI4-Stream beat as seen on the result path.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/sa_out_fifo.sv
// Result buffer: synchronous first-word fall-through FIFO.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset (clears pointers)
//   wr_en, wr_data   push side (ignored when full)
//   rd_en, rd_data   pop side; rd_data shows the head whenever not empty
//   full, empty      registered occupancy flags
module sa_out_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push_c;
  logic             pop_c;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign push_c  = wr_en & ~full;
  assign pop_c   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers and flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_c)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sa_dma_bridge.sv
// Bridge between an AXI DMA (MM2S / S2MM streams) and the systolic-array core.
// Load request (2'b10): streams IN_WORDS words from s_axis into the core input
// RAM. Store request (2'b11): waits CAP_LAT cycles, captures OUT_WORDS words of
// DATA_OUT into a FIFO and drains them on m_axis with tlast on the final word.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   start_rd_wr               core request code
//   DATA_OUT                  core result word, one per cycle during capture
//   read_data_vld, DATA_IN    word strobe/data to the core input RAM
//   s_axis_*                  MM2S input stream
//   m_axis_*                  S2MM output stream
//   busy                      bridge not idle
//   err_tlast                 sticky input-tlast framing error
module sa_dma_bridge
  import sa_dma_pkg::*;
#(
  parameter int unsigned IN_WORDS  = IN_WORDS_DEF,
  parameter int unsigned OUT_WORDS = OUT_WORDS_DEF,
  parameter int unsigned CAP_LAT   = CAP_LAT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REQ_W-1:0]  start_rd_wr,
  input  logic [DATA_W-1:0] DATA_OUT,
  output logic              read_data_vld,
  output logic [DATA_W-1:0] DATA_IN,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              err_tlast
);

  localparam int unsigned WAIT_W = (CAP_LAT > 2) ? $clog2(CAP_LAT) : 1;

  state_e               state;
  state_e               state_nxt;
  logic [IN_CNT_W-1:0]  in_cnt;
  logic [IN_CNT_W-1:0]  in_cnt_nxt;
  logic [OUT_CNT_W-1:0] out_cnt;
  logic [OUT_CNT_W-1:0] out_cnt_nxt;
  logic [OUT_CNT_W-1:0] tx_cnt;
  logic [OUT_CNT_W-1:0] tx_cnt_nxt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [WAIT_W-1:0]    wait_cnt_nxt;
  logic                 pend;
  logic                 pend_nxt;
  logic                 err_nxt;

  logic                 s_hs_c;
  logic                 m_hs_c;
  logic                 in_last_c;
  logic                 fifo_wr_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_W-1:0]    fifo_head;

  assign s_hs_c    = s_axis_tvalid & s_axis_tready;
  assign in_last_c = (in_cnt == IN_CNT_W'(IN_WORDS - 1));
  assign fifo_wr_c = (state == ST_CAPTURE) & ~fifo_full;

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_head;
  assign m_hs_c        = m_axis_tvalid & m_axis_tready;
  // tx_cnt counts words already sent, so the head is the final word at OUT_WORDS-1.
  assign m_axis_tlast  = m_axis_tvalid & (tx_cnt == OUT_CNT_W'(OUT_WORDS - 1));

  sa_out_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_WORDS)
  ) u_out_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (fifo_wr_c),
    .wr_data (DATA_OUT),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state and counter logic.
  always_comb begin
    state_nxt    = state;
    in_cnt_nxt   = in_cnt;
    out_cnt_nxt  = out_cnt;
    tx_cnt_nxt   = tx_cnt;
    wait_cnt_nxt = wait_cnt;
    pend_nxt     = pend;
    err_nxt      = err_tlast;

    if (m_hs_c) tx_cnt_nxt = tx_cnt + OUT_CNT_W'(1);

    // A load arriving during a store is remembered and served from IDLE.
    if ((state == ST_CAP_WAIT || state == ST_CAPTURE || state == ST_DRAIN) &&
        start_rd_wr == REQ_LOAD) begin
      pend_nxt = 1'b1;
    end

    unique case (state)
      ST_IDLE: begin
        if (pend || start_rd_wr == REQ_LOAD) begin
          state_nxt  = ST_FILL;
          in_cnt_nxt = '0;
          pend_nxt   = 1'b0;
        end else if (start_rd_wr == REQ_STORE) begin
          state_nxt    = (CAP_LAT > 1) ? ST_CAP_WAIT : ST_CAPTURE;
          wait_cnt_nxt = '0;
          out_cnt_nxt  = '0;
          tx_cnt_nxt   = '0;
        end
      end
      ST_FILL: begin
        if (s_hs_c) begin
          in_cnt_nxt = in_cnt + IN_CNT_W'(1);
          if (in_last_c != s_axis_tlast) err_nxt = 1'b1;
          if (in_last_c) state_nxt = ST_IDLE;
        end
      end
      ST_CAP_WAIT: begin
        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(CAP_LAT - 2)) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        out_cnt_nxt = out_cnt + OUT_CNT_W'(1);
        if (out_cnt == OUT_CNT_W'(OUT_WORDS - 1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (m_hs_c && m_axis_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Counters, flags and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt        <= '0;
      out_cnt       <= '0;
      tx_cnt        <= '0;
      wait_cnt      <= '0;
      pend          <= 1'b0;
      err_tlast     <= 1'b0;
      read_data_vld <= 1'b0;
      DATA_IN       <= '0;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
    end else begin
      in_cnt        <= in_cnt_nxt;
      out_cnt       <= out_cnt_nxt;
      tx_cnt        <= tx_cnt_nxt;
      wait_cnt      <= wait_cnt_nxt;
      pend          <= pend_nxt;
      err_tlast     <= err_nxt;
      read_data_vld <= s_hs_c;
      if (s_hs_c) DATA_IN <= s_axis_tdata;
      // Ready drops on the final handshake because the FSM leaves FILL there.
      s_axis_tready <= (state_nxt == ST_FILL);
      busy          <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sa_dma_bridge.sv
// Self-checking bench for sa_dma_bridge: scoreboard queues for the core-side
// load words and the m_axis result stream, scenario tasks run in sequence.
module tb_sa_dma_bridge;
  import sa_dma_pkg::*;

  localparam int IN_WORDS  = 32;
  localparam int OUT_WORDS = 16;
  localparam int CAP_LAT   = 2;

  logic        clk;
  logic        rstn;
  logic [1:0]  start_rd_wr;
  logic [31:0] DATA_OUT;
  logic        read_data_vld;
  logic [31:0] DATA_IN;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic        err_tlast;

  int checks;
  int errors;
  int in_seen;
  int m_seen;

  logic [31:0] in_q[$];
  axis_beat_t  m_q[$];

  sa_dma_bridge #(
    .IN_WORDS  (IN_WORDS),
    .OUT_WORDS (OUT_WORDS),
    .CAP_LAT   (CAP_LAT)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_rd_wr   (start_rd_wr),
    .DATA_OUT      (DATA_OUT),
    .read_data_vld (read_data_vld),
    .DATA_IN       (DATA_IN),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .err_tlast     (err_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Core-side monitor: every read_data_vld pulse must carry the next expected word.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (rstn && read_data_vld) begin
      in_seen++;
      checks++;
      if (in_q.size() == 0) begin
        errors++;
        $display("FAIL in_extra DATA_IN got %h want no pulse", DATA_IN);
      end else begin
        exp_w = in_q.pop_front();
        if (DATA_IN !== exp_w) begin
          errors++;
          $display("FAIL in_data DATA_IN got %h want %h", DATA_IN, exp_w);
        end
      end
    end
  end

  // S2MM monitor: scoreboard compare on handshake, stability while stalled.
  always @(negedge clk) begin
    static bit  held_valid = 1'b0;
    axis_beat_t held;
    axis_beat_t exp_b;
    if (!rstn) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held.data || m_axis_tlast !== held.last) begin
          errors++;
          $display("FAIL m_stable got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, held.data, held.last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        m_seen++;
        checks++;
        if (m_q.size() == 0) begin
          errors++;
          $display("FAIL m_extra got d=%h l=%b want no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          exp_b = m_q.pop_front();
          if (m_axis_tdata !== exp_b.data || m_axis_tlast !== exp_b.last) begin
            errors++;
            $display("FAIL m_beat got d=%h l=%b want d=%h l=%b",
                     m_axis_tdata, m_axis_tlast, exp_b.data, exp_b.last);
          end
        end
      end
      held_valid = m_axis_tvalid && !m_axis_tready;
      held.data  = m_axis_tdata;
      held.last  = m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_outputs(input string tag);
    checks++;
    if (read_data_vld !== 1'b0 || DATA_IN !== 32'h0 || s_axis_tready !== 1'b0 ||
        m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 ||
        err_tlast !== 1'b0) begin
      errors++;
      $display("FAIL %s_outputs got vld=%b din=%h srdy=%b mval=%b mlast=%b busy=%b err=%b want all 0",
               tag, read_data_vld, DATA_IN, s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, err_tlast);
    end
  endtask

  // Drives one load of IN_WORDS words base+1..base+IN_WORDS; optional mid-fill reset.
  task automatic run_load(input logic [31:0] base, input int tlast_at, input int rst_at,
                          input bit issue_req);
    int idx;
    int cyc;
    bit hs;
    idx = 0;
    cyc = 0;
    in_seen = 0;
    for (int i = 1; i <= IN_WORDS; i++) in_q.push_back(base + 32'(i));
    if (issue_req) begin
      start_rd_wr = 2'b10;
      tick();
      start_rd_wr = 2'b00;
    end
    s_axis_tvalid = 1'b1;
    while (idx < IN_WORDS && cyc < 200) begin
      s_axis_tdata = base + 32'(idx + 1);
      s_axis_tlast = (idx + 1 == tlast_at);
      @(negedge clk);
      hs = s_axis_tready;
      tick();
      cyc++;
      if (hs) idx++;
      if (rst_at != 0 && idx == rst_at) begin
        rstn = 1'b0;
        #1;
        in_q.delete();
        expect_reset_outputs("mid_fill_reset");
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        return;
      end
    end
    checks++;
    if (idx != IN_WORDS) begin
      errors++;
      $display("FAIL load_accept got %0d want %0d", idx, IN_WORDS);
    end
    // Keep offering data: nothing more may be accepted.
    s_axis_tdata = 32'hBAD0_0000;
    s_axis_tlast = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL load_overrun s_axis_tready got %b want 0", s_axis_tready);
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (in_seen != IN_WORDS || in_q.size() != 0) begin
      errors++;
      $display("FAIL load_count got %0d pulses (%0d left) want %0d", in_seen, in_q.size(), IN_WORDS);
    end
  endtask

  // Drives a store request and the DATA_OUT timeline; returns at the first idle cycle.
  task automatic run_store(input int stall, input int load_at, input int restore_at);
    axis_beat_t b;
    int n;
    m_seen = 0;
    for (int k = 0; k < OUT_WORDS; k++) begin
      b.last = (k == OUT_WORDS - 1);
      b.data = 32'hA0 + 32'(k);
      m_q.push_back(b);
    end
    m_axis_tready = (stall == 0);
    start_rd_wr = 2'b11;
    tick();
    n = 1;
    while (n < 150) begin
      start_rd_wr = (n == load_at) ? 2'b10 : ((n == restore_at) ? 2'b11 : 2'b00);
      DATA_OUT = (n >= CAP_LAT && n < CAP_LAT + OUT_WORDS) ? 32'hA0 + 32'(n - CAP_LAT)
                                                           : 32'hDEAD_0000 + 32'(n);
      if (n >= stall) m_axis_tready = 1'b1;
      tick();
      n++;
      if (!busy) break;
    end
    start_rd_wr = 2'b00;
    DATA_OUT = 32'h0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL store_done busy got %b want 0", busy);
    end
    checks++;
    if (m_seen != OUT_WORDS || m_q.size() != 0) begin
      errors++;
      $display("FAIL store_count got %0d beats (%0d left) want %0d", m_seen, m_q.size(), OUT_WORDS);
      m_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b srdy=%b want 0 0", busy, s_axis_tready);
    end
  endtask

  task automatic test_load();
    run_load(32'h0, IN_WORDS, 0, 1'b1);
    checks++;
    if (err_tlast !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_flags got err=%b busy=%b want 0 0", err_tlast, busy);
    end
  endtask

  task automatic test_store();
    run_store(0, 0, 0);
    tick();
    checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL store_after got busy=%b mval=%b want 0 0", busy, m_axis_tvalid);
    end
  endtask

  task automatic test_store_stall();
    run_store(20, 0, 5);
  endtask

  task automatic test_tlast_err();
    run_load(32'h1000, 16, 0, 1'b1);
    checks++;
    if (err_tlast !== 1'b1) begin
      errors++;
      $display("FAIL tlast_err got %b want 1", err_tlast);
    end
    run_store(0, 0, 0);
    checks++;
    if (err_tlast !== 1'b1) begin
      errors++;
      $display("FAIL tlast_sticky got %b want 1", err_tlast);
    end
  endtask

  task automatic test_pending_reset();
    run_store(CAP_LAT + OUT_WORDS + 5, CAP_LAT + OUT_WORDS + 2, 0);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL pend_idle s_axis_tready got %b want 0", s_axis_tready);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL pend_fill got busy=%b srdy=%b want 1 1", busy, s_axis_tready);
    end
    run_load(32'h200, IN_WORDS, 10, 1'b0);
    run_load(32'h300, IN_WORDS, 0, 1'b1);
    checks++;
    if (err_tlast !== 1'b0) begin
      errors++;
      $display("FAIL fresh_load err_tlast got %b want 0", err_tlast);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    in_seen       = 0;
    m_seen        = 0;
    rstn          = 1'b0;
    start_rd_wr   = 2'b00;
    DATA_OUT      = 32'h0;
    s_axis_tdata  = 32'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    test_reset();
    test_load();
    test_store();
    test_store_stall();
    test_tlast_err();
    test_pending_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
